// File: rtl/regfile_pkg.sv
// Shared helpers and types for the scoreboarded register file.
package regfile_pkg;

  function automatic int reg_aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  localparam int NREG_DEFAULT   = 32;
  localparam int PEND_W_DEFAULT = 2;
  localparam int REG_ZERO       = 0;

  typedef logic [reg_aw(NREG_DEFAULT)-1:0] reg_addr_t;
  typedef logic [PEND_W_DEFAULT-1:0]       pend_t;

endpackage

// File: rtl/regfile_pend_cnt.sv
// Per-register count of in-flight writes; never wraps in either direction.
// REGFILE_BYPASS_EN adds a last_o flag (exactly one write outstanding) for forwarding.
module regfile_pend_cnt #(
  parameter int PEND_W = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
`ifdef REGFILE_BYPASS_EN
  output logic last_o,
`endif
  output logic busy_o,
  output logic sat_o,
  output logic underflow_o
);

  logic [PEND_W-1:0] cnt_q, cnt_d;
  logic              decEff;

  assign busy_o      = (cnt_q != '0);
  assign sat_o       = &cnt_q;
  assign underflow_o = dec_i && !busy_o;
  assign decEff      = dec_i && busy_o;
`ifdef REGFILE_BYPASS_EN
  assign last_o      = (cnt_q == PEND_W'(1));
`endif

  // A retiring write and a new issue in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !decEff && !sat_o) begin
      cnt_d = cnt_q + 1'b1;
    end else if (decEff && !inc_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with NRD read ports, one write-back port and a pending-write scoreboard.
// REGFILE_BYPASS_EN forwards write-back data to the read ports in the same cycle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int PEND_W = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              issue_valid_i,
  output logic                              issue_ready_o,
  input  logic                              issue_rd_we_i,
  input  logic [reg_aw(NREG)-1:0]           issue_rd_addr_i,
  input  logic [NRD-1:0]                    rs_use_i,
  input  logic [NRD*reg_aw(NREG)-1:0]       rs_addr_i,
  output logic [NRD*XLEN-1:0]               rs_data_o,
  output logic [NRD-1:0]                    rs_busy_o,
  input  logic                              wb_wren_i,
  input  logic [reg_aw(NREG)-1:0]           wb_addr_i,
  input  logic [XLEN-1:0]                   wb_data_i,
  output logic                              err_o
);

  localparam int AW = reg_aw(NREG);

  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] busyVec;
  logic [NREG-1:0] satVec;
  logic [NREG-1:0] underflowVec;
  logic            accept;
  logic            useStall;
  logic            satStall;
  logic            err_q;

  assign busyVec[0]      = 1'b0;
  assign satVec[0]       = 1'b0;
  assign underflowVec[0] = 1'b0;

`ifdef REGFILE_BYPASS_EN
  logic [NREG-1:0] lastVec;
  assign lastVec[0] = 1'b0;
`endif

  for (genvar r = 1; r < NREG; r++) begin : g_pend
    regfile_pend_cnt #(
      .PEND_W(PEND_W)
    ) u_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .inc_i       (accept && issue_rd_we_i && (issue_rd_addr_i == AW'(r))),
      .dec_i       (wb_wren_i && (wb_addr_i == AW'(r))),
`ifdef REGFILE_BYPASS_EN
      .last_o      (lastVec[r]),
`endif
      .busy_o      (busyVec[r]),
      .sat_o       (satVec[r]),
      .underflow_o (underflowVec[r])
    );
  end

  // Entry 0 is only ever reset, so it reads as zero without a special case.
  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [AW-1:0] addr;
    assign addr = rs_addr_i[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = wb_wren_i && (wb_addr_i == addr) && (addr != AW'(REG_ZERO));
    assign rs_data_o[k*XLEN +: XLEN] = hit ? wb_data_i : mem_q[addr];
    assign rs_busy_o[k] = busyVec[addr] && !(hit && lastVec[addr]);
`else
    assign rs_data_o[k*XLEN +: XLEN] = mem_q[addr];
    assign rs_busy_o[k] = busyVec[addr];
`endif
  end

  assign useStall      = |(rs_use_i & rs_busy_o);
  assign satStall      = issue_rd_we_i && (issue_rd_addr_i != AW'(REG_ZERO)) && satVec[issue_rd_addr_i];
  assign issue_ready_o = !useStall && !satStall;
  assign accept        = issue_valid_i && issue_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wb_wren_i && (wb_addr_i != AW'(REG_ZERO))) begin
      mem_q[wb_addr_i] <= wb_data_i;
    end
  end

  // A write-back to a non-pending register marks a broken scoreboard until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q || (|underflowVec);
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard at default parameters.
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                issue_valid_i;
  logic                issue_ready_o;
  logic                issue_rd_we_i;
  logic [AW-1:0]       issue_rd_addr_i;
  logic [NRD-1:0]      rs_use_i;
  logic [NRD*AW-1:0]   rs_addr_i;
  logic [NRD*XLEN-1:0] rs_data_o;
  logic [NRD-1:0]      rs_busy_o;
  logic                wb_wren_i;
  logic [AW-1:0]       wb_addr_i;
  logic [XLEN-1:0]     wb_data_i;
  logic                err_o;

  int vecCount  = 0;
  int missCount = 0;

  regfile_scoreboard dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .issue_valid_i   (issue_valid_i),
    .issue_ready_o   (issue_ready_o),
    .issue_rd_we_i   (issue_rd_we_i),
    .issue_rd_addr_i (issue_rd_addr_i),
    .rs_use_i        (rs_use_i),
    .rs_addr_i       (rs_addr_i),
    .rs_data_o       (rs_data_o),
    .rs_busy_o       (rs_busy_o),
    .wb_wren_i       (wb_wren_i),
    .wb_addr_i       (wb_addr_i),
    .wb_data_i       (wb_data_i),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic we, input logic [AW-1:0] rd,
                               input logic [NRD-1:0] use_, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic wbEn, input logic [AW-1:0] wbAddr, input logic [XLEN-1:0] wbData);
    issue_valid_i   = valid;
    issue_rd_we_i   = we;
    issue_rd_addr_i = rd;
    rs_use_i        = use_;
    rs_addr_i       = {a1, a0};
    wb_wren_i       = wbEn;
    wb_addr_i       = wbAddr;
    wb_data_i       = wbData;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_i = 1'b0;

    // Reset state.
    applyStimulus(0, 0, 0, 2'b00, 5, 31, 0, 0, 0);
    checkOutput("rst_data0", rs_data_o[31:0], 0);
    checkOutput("rst_data1", rs_data_o[63:32], 0);
    checkOutput("rst_busy", rs_busy_o, 0);
    checkOutput("rst_ready", issue_ready_o, 1);
    checkOutput("rst_err", err_o, 0);

    // RAW hazard on x3.
    applyStimulus(1, 1, 3, 2'b00, 0, 0, 0, 0, 0);
    checkOutput("raw_issue_ready", issue_ready_o, 1);
    tick();
    applyStimulus(1, 0, 0, 2'b01, 3, 0, 0, 0, 0);
    checkOutput("raw_busy", rs_busy_o[0], 1);
    checkOutput("raw_stall", issue_ready_o, 0);
    tick();
    applyStimulus(1, 0, 0, 2'b01, 3, 0, 1, 3, 32'hDEADBEEF);
`ifdef REGFILE_BYPASS_EN
    checkOutput("raw_wb_ready", issue_ready_o, 1);
    checkOutput("raw_wb_data", rs_data_o[31:0], 32'hDEADBEEF);
`else
    checkOutput("raw_wb_ready", issue_ready_o, 0);
    checkOutput("raw_wb_data", rs_data_o[31:0], 0);
`endif
    tick();
    applyStimulus(1, 0, 0, 2'b01, 3, 0, 0, 0, 0);
    checkOutput("raw_after_ready", issue_ready_o, 1);
    checkOutput("raw_after_data", rs_data_o[31:0], 32'hDEADBEEF);
    checkOutput("raw_after_busy", rs_busy_o[0], 0);
    tick();

    // Saturate x7 at three outstanding writes.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 7, 2'b00, 7, 0, 0, 0, 0);
      checkOutput("sat_issue_ready", issue_ready_o, 1);
      tick();
    end
    applyStimulus(1, 1, 7, 2'b00, 7, 0, 0, 0, 0);
    checkOutput("sat_full_ready", issue_ready_o, 0);
    applyStimulus(1, 1, 7, 2'b00, 7, 0, 1, 7, 32'h7);
    checkOutput("sat_wb_ready", issue_ready_o, 0);
    tick();
    applyStimulus(0, 1, 7, 2'b00, 7, 0, 0, 0, 0);
    checkOutput("sat_freed_ready", issue_ready_o, 1);
    checkOutput("sat_busy_pend2", rs_busy_o[0], 1);
    applyStimulus(0, 0, 0, 2'b00, 7, 0, 1, 7, 32'h77);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 7, 0, 0, 0, 0);
    checkOutput("sat_busy_pend1", rs_busy_o[0], 1);
    applyStimulus(0, 0, 0, 2'b00, 7, 0, 1, 7, 32'h777);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 7, 0, 0, 0, 0);
    checkOutput("sat_busy_pend0", rs_busy_o[0], 0);
    checkOutput("sat_data", rs_data_o[31:0], 32'h777);
    checkOutput("sat_err", err_o, 0);

    // Issue and write-back to x9 in the same cycle.
    applyStimulus(1, 1, 9, 2'b00, 9, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 9, 2'b00, 9, 0, 1, 9, 32'h55);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 9, 0, 0, 0, 0);
    checkOutput("simul_busy", rs_busy_o[0], 1);
    checkOutput("simul_data", rs_data_o[31:0], 32'h55);
    applyStimulus(0, 0, 0, 2'b00, 9, 0, 1, 9, 32'h56);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 9, 0, 0, 0, 0);
    checkOutput("simul_drained", rs_busy_o[0], 0);
    checkOutput("simul_err", err_o, 0);

    // x0 is never pending and never written.
    applyStimulus(1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 2'b01, 0, 0, 0, 0, 0);
    checkOutput("x0_busy", rs_busy_o[0], 0);
    checkOutput("x0_ready", issue_ready_o, 1);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 1, 0, 32'hFFFF);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0, 12, 0, 0, 0);
    checkOutput("x0_data", rs_data_o[31:0], 0);
    checkOutput("x0_err", err_o, 0);
    applyStimulus(0, 0, 0, 2'b00, 0, 12, 1, 12, 32'h1234);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0, 12, 0, 0, 0);
    checkOutput("x12_err_set", err_o, 1);
    checkOutput("x12_data", rs_data_o[63:32], 32'h1234);
    tick();
    tick();
    checkOutput("x12_err_sticky", err_o, 1);

    // Reset in the same cycle as a write-back to pending x4.
    applyStimulus(1, 1, 4, 2'b00, 4, 12, 0, 0, 0);
    tick();
    tick();
    applyStimulus(0, 0, 0, 2'b00, 4, 12, 0, 0, 0);
    checkOutput("midrst_pre_busy", rs_busy_o[0], 1);
    rst_i = 1'b1;
    applyStimulus(0, 0, 0, 2'b00, 4, 12, 1, 4, 32'hAAAA);
    tick();
    rst_i = 1'b0;
    applyStimulus(0, 0, 0, 2'b00, 4, 12, 0, 0, 0);
    checkOutput("midrst_busy", rs_busy_o[0], 0);
    checkOutput("midrst_data4", rs_data_o[31:0], 0);
    checkOutput("midrst_data12", rs_data_o[63:32], 0);
    checkOutput("midrst_err", err_o, 0);
    checkOutput("midrst_ready", issue_ready_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
